// File: rtl/lieat_axi_sram_slave.sv
// rtl/lieat_axi_sram_slave.sv - AXI4 responder backed by a word-addressed register-array SRAM
//
// Purpose: far end of the core's io_master_* port for simulation/FPGA builds. Independent
//   read and write engines, one outstanding burst per direction, transaction IDs echoed.
// Ports:
//   clock, reset            system clock, synchronous active-high reset
//   io_slave_aw*            write address channel (ready/valid, addr, id, len, size, burst)
//   io_slave_w*             write data channel (ready/valid, data, strb, last)
//   io_slave_b*             write response channel (valid/ready, resp, id)
//   io_slave_ar*            read address channel (ready/valid, addr, id, len, size, burst)
//   io_slave_r*             read data channel (valid/ready, data, resp, last, id)
module lieat_axi_sram_slave #(
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int          MEM_AW     = 12,
  parameter int          RD_LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic        io_slave_awready,
  input  logic        io_slave_awvalid,
  input  logic [31:0] io_slave_awaddr,
  input  logic [3:0]  io_slave_awid,
  input  logic [7:0]  io_slave_awlen,
  input  logic [2:0]  io_slave_awsize,
  input  logic [1:0]  io_slave_awburst,
  output logic        io_slave_wready,
  input  logic        io_slave_wvalid,
  input  logic [31:0] io_slave_wdata,
  input  logic [3:0]  io_slave_wstrb,
  input  logic        io_slave_wlast,
  output logic        io_slave_bvalid,
  input  logic        io_slave_bready,
  output logic [1:0]  io_slave_bresp,
  output logic [3:0]  io_slave_bid,
  output logic        io_slave_arready,
  input  logic        io_slave_arvalid,
  input  logic [31:0] io_slave_araddr,
  input  logic [3:0]  io_slave_arid,
  input  logic [7:0]  io_slave_arlen,
  input  logic [2:0]  io_slave_arsize,
  input  logic [1:0]  io_slave_arburst,
  input  logic        io_slave_rready,
  output logic        io_slave_rvalid,
  output logic [31:0] io_slave_rdata,
  output logic [1:0]  io_slave_rresp,
  output logic        io_slave_rlast,
  output logic [3:0]  io_slave_rid
);

  localparam logic [31:0] MEM_BYTES = 32'(4 << MEM_AW);
  localparam int          WORDS     = 1 << MEM_AW;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  logic [31:0] mem [WORDS];

  // ---------------- read engine ----------------
  r_state_t    r_state, r_next;
  logic [31:0] r_addr, r_addr_inc, ld_addr, ld_off, ld_word;
  logic [3:0]  r_id;
  logic [7:0]  r_len, r_beat, r_cnt;
  logic [2:0]  r_size, ld_size;
  logic [1:0]  r_burst, r_resp_q;
  logic [31:0] r_data_q;
  logic        r_last, r_load, ld_inr, r_out;

  assign r_last     = (r_beat == r_len);
  assign r_addr_inc = (r_burst == 2'b00) ? r_addr : r_addr + (32'd1 << r_size);

  // The beat's data is captured into r_data_q on the edge that enters (or advances within)
  // R_DATA, so a write landing on that same edge is not visible and rdata stays stable
  // while rready is low.
  assign ld_off  = ld_addr - BASE_ADDR;
  assign ld_inr  = (ld_off < MEM_BYTES);
  assign ld_word = mem[ld_addr[MEM_AW+1:2]];

  always_ff @(posedge clock) begin
    if (reset) r_state <= R_IDLE;
    else       r_state <= r_next;
  end

  always_comb begin
    r_next  = r_state;
    r_load  = 1'b0;
    ld_addr = r_addr;
    ld_size = r_size;
    case (r_state)
      R_IDLE: begin
        if (io_slave_arvalid) begin
          ld_addr = io_slave_araddr;
          ld_size = io_slave_arsize;
          if (RD_LATENCY == 0) begin
            r_next = R_DATA;
            r_load = 1'b1;
          end else begin
            r_next = R_WAIT;
          end
        end
      end
      R_WAIT: begin
        if (r_cnt <= 8'd1) begin
          r_next = R_DATA;
          r_load = 1'b1;
        end
      end
      R_DATA: begin
        if (io_slave_rready) begin
          if (r_last) begin
            r_next = R_IDLE;
          end else begin
            r_load  = 1'b1;
            ld_addr = r_addr_inc;
          end
        end
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (r_state == R_IDLE && io_slave_arvalid) begin
      r_addr  <= io_slave_araddr;
      r_id    <= io_slave_arid;
      r_len   <= io_slave_arlen;
      r_size  <= io_slave_arsize;
      r_burst <= io_slave_arburst;
      r_beat  <= 8'd0;
      r_cnt   <= 8'(RD_LATENCY);
    end else if (r_state == R_WAIT) begin
      r_cnt <= r_cnt - 8'd1;
    end else if (r_state == R_DATA && io_slave_rready && !r_last) begin
      r_beat <= r_beat + 8'd1;
      r_addr <= r_addr_inc;
    end
    if (r_load) begin
      r_data_q <= (ld_inr && ld_size <= 3'd2) ? ld_word : 32'd0;
      r_resp_q <= !ld_inr ? 2'b11 : (ld_size > 3'd2) ? 2'b10 : 2'b00;
    end
  end

  assign r_out            = !reset && (r_state == R_DATA);
  assign io_slave_arready = !reset && (r_state == R_IDLE);
  assign io_slave_rvalid  = r_out;
  assign io_slave_rdata   = r_out ? r_data_q : 32'd0;
  assign io_slave_rresp   = r_out ? r_resp_q : 2'b00;
  assign io_slave_rlast   = r_out && r_last;
  assign io_slave_rid     = r_out ? r_id : 4'd0;

  // ---------------- write engine ----------------
  w_state_t    w_state, w_next;
  logic [31:0] w_addr, w_off;
  logic [3:0]  w_id;
  logic [7:0]  w_len, w_beat;
  logic [2:0]  w_size;
  logic [1:0]  w_burst, w_err, w_err_nxt;
  logic        w_inr, w_last, w_fire, w_out;

  assign w_off  = w_addr - BASE_ADDR;
  assign w_inr  = (w_off < MEM_BYTES);
  assign w_last = (w_beat == w_len);
  assign w_fire = !reset && (w_state == W_DATA) && io_slave_wvalid;

  // DECERR is sticky: once set, later SLVERR conditions cannot downgrade it.
  always_comb begin
    w_err_nxt = w_err;
    if (!w_inr)                                    w_err_nxt = 2'b11;
    else if (w_size > 3'd2 && w_err_nxt != 2'b11)  w_err_nxt = 2'b10;
    if (io_slave_wlast != w_last && w_err_nxt != 2'b11) w_err_nxt = 2'b10;
  end

  always_ff @(posedge clock) begin
    if (reset) w_state <= W_IDLE;
    else       w_state <= w_next;
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (io_slave_awvalid)           w_next = W_DATA;
      W_DATA:  if (io_slave_wvalid && w_last)  w_next = W_RESP;
      W_RESP:  if (io_slave_bready)            w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (w_state == W_IDLE && io_slave_awvalid) begin
      w_addr  <= io_slave_awaddr;
      w_id    <= io_slave_awid;
      w_len   <= io_slave_awlen;
      w_size  <= io_slave_awsize;
      w_burst <= io_slave_awburst;
      w_beat  <= 8'd0;
      w_err   <= 2'b00;
    end else if (w_fire) begin
      w_err <= w_err_nxt;
      if (!w_last) begin
        w_beat <= w_beat + 8'd1;
        if (w_burst != 2'b00) w_addr <= w_addr + (32'd1 << w_size);
      end
    end
  end

  // SRAM contents are deliberately not reset.
  always_ff @(posedge clock) begin
    if (w_fire && w_inr && w_size <= 3'd2) begin
      for (int i = 0; i < 4; i++) begin
        if (io_slave_wstrb[i]) mem[w_addr[MEM_AW+1:2]][8*i +: 8] <= io_slave_wdata[8*i +: 8];
      end
    end
  end

  assign w_out            = !reset && (w_state == W_RESP);
  assign io_slave_awready = !reset && (w_state == W_IDLE);
  assign io_slave_wready  = !reset && (w_state == W_DATA);
  assign io_slave_bvalid  = w_out;
  assign io_slave_bresp   = w_out ? w_err : 2'b00;
  assign io_slave_bid     = w_out ? w_id : 4'd0;

endmodule

// File: tb/tb_lieat_axi_sram_slave.sv
// tb/tb_lieat_axi_sram_slave.sv - scoreboard bench for lieat_axi_sram_slave
module tb_lieat_axi_sram_slave;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int          AW   = 12;
  localparam int          LAT  = 2;
  localparam logic [31:0] MEM_BYTES = 32'(4 << AW);

  logic        clock, reset;
  logic        awready, awvalid, wready, wvalid, wlast, bvalid, bready;
  logic        arready, arvalid, rready, rvalid, rlast;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [3:0]  awid, arid, wstrb, bid, rid;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;

  lieat_axi_sram_slave #(.BASE_ADDR(BASE), .MEM_AW(AW), .RD_LATENCY(LAT)) dut (
    .clock(clock), .reset(reset),
    .io_slave_awready(awready), .io_slave_awvalid(awvalid), .io_slave_awaddr(awaddr),
    .io_slave_awid(awid), .io_slave_awlen(awlen), .io_slave_awsize(awsize), .io_slave_awburst(awburst),
    .io_slave_wready(wready), .io_slave_wvalid(wvalid), .io_slave_wdata(wdata),
    .io_slave_wstrb(wstrb), .io_slave_wlast(wlast),
    .io_slave_bvalid(bvalid), .io_slave_bready(bready), .io_slave_bresp(bresp), .io_slave_bid(bid),
    .io_slave_arready(arready), .io_slave_arvalid(arvalid), .io_slave_araddr(araddr),
    .io_slave_arid(arid), .io_slave_arlen(arlen), .io_slave_arsize(arsize), .io_slave_arburst(arburst),
    .io_slave_rready(rready), .io_slave_rvalid(rvalid), .io_slave_rdata(rdata),
    .io_slave_rresp(rresp), .io_slave_rlast(rlast), .io_slave_rid(rid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
  } rbeat_t;

  rbeat_t      rq[$];
  logic [5:0]  bq[$];
  logic [31:0] model [4096];
  logic [31:0] wdat [256];
  logic [3:0]  wstb [256];
  logic        wlst [256];
  int          checks = 0;
  int          failures = 0;
  int          rmode = 2;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout expected=handshake", name);
  endtask

  function automatic logic in_range(input logic [31:0] a);
    return (a - BASE) < MEM_BYTES;
  endfunction

  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [2:0] size,
                                            input logic [1:0] burst);
    return (burst == 2'b00) ? a : a + (32'd1 << size);
  endfunction

  // Ready generators for the response channels.
  initial begin
    rready = 1'b0;
    bready = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      case (rmode)
        0:       rready = 1'($urandom_range(0, 1));
        1:       rready = ~rready;
        default: rready = 1'b1;
      endcase
      bready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: pops the scoreboard whenever the DUT completes a handshake.
  rbeat_t     e;
  logic [5:0] eb;
  initial forever begin
    @(negedge clock);
    if (!reset && rvalid && rready) begin
      if (rq.size() == 0) begin
        checks++; failures++;
        $display("FAIL r_unexpected actual=beat data=%h expected=none", rdata);
      end else begin
        e = rq.pop_front();
        check("r_beat{id,resp,last,data}", {rid, rresp, rlast, rdata}, {e.id, e.resp, e.last, e.data});
      end
    end
    if (!reset && bvalid && bready) begin
      if (bq.size() == 0) begin
        checks++; failures++;
        $display("FAIL b_unexpected actual=resp%0d expected=none", bresp);
      end else begin
        eb = bq.pop_front();
        check("b_resp{id,resp}", {bid, bresp}, eb);
      end
    end
  end

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((rq.size() != 0 || bq.size() != 0) && n < budget) begin
      @(posedge clock);
      n++;
    end
    if (rq.size() != 0 || bq.size() != 0) begin
      fail_now("drain");
      rq.delete();
      bq.delete();
    end
    @(posedge clock);
    #1;
  endtask

  task automatic model_write(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] a = addr;
    logic [1:0]  err = 2'b00;
    for (int b = 0; b <= int'(len); b++) begin
      if (!in_range(a)) err = 2'b11;
      else if (size > 3'd2) begin
        if (err != 2'b11) err = 2'b10;
      end else begin
        for (int i = 0; i < 4; i++)
          if (wstb[b][i]) model[a[AW+1:2]][8*i +: 8] = wdat[b][8*i +: 8];
      end
      if (wlst[b] != (b == int'(len)) && err != 2'b11) err = 2'b10;
      a = next_addr(a, size, burst);
    end
    bq.push_back({id, err});
  endtask

  task automatic model_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] a = addr;
    rbeat_t x;
    for (int b = 0; b <= int'(len); b++) begin
      x.id   = id;
      x.last = (b == int'(len));
      if (!in_range(a))      begin x.resp = 2'b11; x.data = 32'd0; end
      else if (size > 3'd2)  begin x.resp = 2'b10; x.data = 32'd0; end
      else                   begin x.resp = 2'b00; x.data = model[a[AW+1:2]]; end
      rq.push_back(x);
      a = next_addr(a, size, burst);
    end
  endtask

  task automatic write_burst(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst);
    int n;
    model_write(addr, id, len, size, burst);
    awaddr = addr; awid = id; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    n = 0;
    do begin @(negedge clock); n++; end while (!awready && n < 50);
    if (!awready) fail_now("aw_handshake");
    @(posedge clock); #1;
    awvalid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      wdata = wdat[b]; wstrb = wstb[b]; wlast = wlst[b]; wvalid = 1'b1;
      n = 0;
      do begin @(negedge clock); n++; end while (!wready && n < 50);
      if (!wready) fail_now("w_handshake");
      @(posedge clock); #1;
      wvalid = 1'b0;
      if ($urandom_range(0, 3) == 0) begin @(posedge clock); #1; end
    end
    wait_drain(200);
  endtask

  task automatic read_burst(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
    int n;
    model_read(addr, id, len, size, burst);
    araddr = addr; arid = id; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    n = 0;
    do begin @(negedge clock); n++; end while (!arready && n < 50);
    if (!arready) fail_now("ar_handshake");
    @(posedge clock); #1;
    arvalid = 1'b0;
    n = 0;
    do begin @(negedge clock); n++; end while (!rvalid && n < 20);
    check("rd_first_beat_latency", n, LAT + 1);
    wait_drain(40 * (int'(len) + 1) + 50);
  endtask

  task automatic fill(input int len, input logic [3:0] strb);
    for (int b = 0; b <= len; b++) begin
      wdat[b] = $urandom;
      wstb[b] = strb;
      wlst[b] = (b == len);
    end
  endtask

  logic [31:0] a;
  logic [7:0]  ln;
  logic [2:0]  sz;
  int          sel;

  initial begin
    reset = 1'b1;
    awvalid = 0; awaddr = 0; awid = 0; awlen = 0; awsize = 0; awburst = 0;
    wvalid = 0; wdata = 0; wstrb = 0; wlast = 0;
    arvalid = 0; araddr = 0; arid = 0; arlen = 0; arsize = 0; arburst = 0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_readies", {awready, wready, arready}, 3'b000);
    check("reset_valids", {bvalid, rvalid, rlast}, 3'b000);
    check("reset_data", {rdata, rresp, rid, bresp, bid}, 44'd0);
    reset = 1'b0;
    @(negedge clock);
    check("idle_readies{aw,w,ar}", {awready, wready, arready}, 3'b101);
    wvalid = 1'b1;
    @(negedge clock);
    check("w_before_aw_wready", wready, 1'b0);
    wvalid = 1'b0;
    @(posedge clock); #1;

    // Initialise the regions later read back, including the top of the array.
    fill(63, 4'hF);
    write_burst(BASE, 4'd1, 8'd63, 3'd2, 2'b01);
    fill(7, 4'hF);
    write_burst(BASE + MEM_BYTES - 32, 4'd2, 8'd7, 3'd2, 2'b01);

    // Single-word write then readback.
    wdat[0] = 32'hDEAD_BEEF; wstb[0] = 4'hF; wlst[0] = 1'b1;
    write_burst(32'h8000_0010, 4'd3, 8'd0, 3'd2, 2'b01);
    read_burst(32'h8000_0010, 4'd4, 8'd0, 3'd2, 2'b01);

    // Byte strobes.
    wdat[0] = 32'hFFFF_FFFF; wstb[0] = 4'hF; wlst[0] = 1'b1;
    write_burst(32'h8000_0020, 4'd5, 8'd0, 3'd2, 2'b01);
    wdat[0] = 32'h1122_3344; wstb[0] = 4'b0101;
    write_burst(32'h8000_0020, 4'd6, 8'd0, 3'd2, 2'b01);
    read_burst(32'h8000_0020, 4'd7, 8'd0, 3'd2, 2'b01);

    // INCR burst with rready toggling.
    rmode = 1;
    read_burst(BASE, 4'd5, 8'd3, 3'd2, 2'b01);
    rmode = 2;

    // Out-of-range accesses; the write must not alias onto word 0.
    read_burst(32'h0000_1000, 4'd8, 8'd0, 3'd2, 2'b01);
    wdat[0] = 32'h0BAD_0BAD; wstb[0] = 4'hF; wlst[0] = 1'b1;
    write_burst(32'h9000_0000, 4'd9, 8'd0, 3'd2, 2'b01);
    read_burst(BASE, 4'd10, 8'd0, 3'd2, 2'b01);

    // Early wlast and oversize read.
    wdat[0] = 32'hAAAA_0001; wdat[1] = 32'hAAAA_0002;
    wstb[0] = 4'hF; wstb[1] = 4'hF; wlst[0] = 1'b1; wlst[1] = 1'b0;
    write_burst(32'h8000_0040, 4'd11, 8'd1, 3'd2, 2'b01);
    read_burst(32'h8000_0040, 4'd12, 8'd1, 3'd2, 2'b01);
    read_burst(BASE, 4'd13, 8'd1, 3'd3, 2'b01);

    // Write beat lands on the same edge as the read data capture: old data returned.
    model_read(32'h8000_0008, 4'd14, 8'd0, 3'd2, 2'b01);
    wdat[0] = 32'h5A5A_A5A5; wstb[0] = 4'hF; wlst[0] = 1'b1;
    model_write(32'h8000_0008, 4'd15, 8'd0, 3'd2, 2'b01);
    araddr = 32'h8000_0008; arid = 4'd14; arlen = 0; arsize = 3'd2; arburst = 2'b01;
    awaddr = 32'h8000_0008; awid = 4'd15; awlen = 0; awsize = 3'd2; awburst = 2'b01;
    arvalid = 1'b1; awvalid = 1'b1;
    @(negedge clock);
    check("concurrent_readies{aw,ar}", {awready, arready}, 2'b11);
    @(posedge clock); #1;
    arvalid = 1'b0; awvalid = 1'b0;
    repeat (LAT - 1) begin @(posedge clock); #1; end
    wdata = wdat[0]; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
    @(negedge clock);
    check("concurrent_wready", wready, 1'b1);
    @(posedge clock); #1;
    wvalid = 1'b0;
    wait_drain(100);
    read_burst(32'h8000_0008, 4'd1, 8'd0, 3'd2, 2'b01);

    // Reset during the read latency window.
    araddr = 32'h8000_0004; arid = 4'd6; arlen = 8'd2; arvalid = 1'b1;
    @(negedge clock);
    @(posedge clock); #1;
    arvalid = 1'b0;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("post_reset{rvalid,arready}", {rvalid, arready}, 2'b01);
    repeat (LAT + 3) @(negedge clock);
    check("post_reset_no_beat", rvalid, 1'b0);
    @(posedge clock); #1;

    // Randomised traffic, including bursts running off the top of the array.
    rmode = 0;
    for (int it = 0; it < 40; it++) begin
      sel = $urandom_range(0, 9);
      if (sel < 7)      a = BASE + 4 * $urandom_range(0, 55);
      else if (sel < 9) a = BASE + MEM_BYTES - 32 + 4 * $urandom_range(0, 7);
      else              a = 32'h1000_0000 + 32'($urandom_range(0, 4095));
      a  = a + 32'($urandom_range(0, 3));
      ln = 8'($urandom_range(0, 7));
      sz = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) begin
        for (int b = 0; b <= int'(ln); b++) begin
          wdat[b] = $urandom;
          wstb[b] = 4'($urandom);
          wlst[b] = (b == int'(ln)) ^ ($urandom_range(0, 15) == 0);
        end
        write_burst(a, 4'($urandom), ln, sz, 2'($urandom_range(0, 2)));
      end else begin
        read_burst(a, 4'($urandom), ln, sz, 2'($urandom_range(0, 2)));
      end
    end

    wait_drain(200);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
